// File: rtl/signal_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : signal_seq_pkg
// Description : Shared types and default sizes for the acquisition
//               scheduler (signal_seq_ctrl) and its interval timer.
// Revision    : 1.0  initial release
// ============================================================================
package signal_seq_pkg;

    // Default width of frame/pixel/laser counts and indices
    localparam int unsigned CNT_W_DFLT      = 8;
    // Default width of the laser period
    localparam int unsigned PER_W_DFLT      = 32;
    // Default WAIT_TX timeout: 100 ms at 100 MHz
    localparam int unsigned TX_TIMEOUT_DFLT = 24'd10_000_000;

    // Scheduler states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FRAME   = 3'd1,
        S_PIXEL   = 3'd2,
        S_LASER   = 3'd3,
        S_GAP     = 3'd4,
        S_WAIT_TX = 3'd5
    } seq_state_t;

endpackage : signal_seq_pkg
`default_nettype wire

// File: rtl/seq_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : seq_interval_timer
// Description : Loadable down-counter. While enabled it raises o_tick for one
//               cycle every i_period cycles (i_period >= 1). Loading restarts
//               the interval so the first tick arrives i_period cycles after
//               the load edge.
// Revision    : 1.0  initial release
// ============================================================================
module seq_interval_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_period,
    output logic         o_tick
);

    localparam logic [W-1:0] c_one = W'(1);

    logic [W-1:0] r_reload;
    logic [W-1:0] r_cnt;

    // Count down while enabled; reload on terminal count or on explicit load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_reload <= i_period - c_one;
            r_cnt    <= i_period - c_one;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= r_reload;
            end else begin
                r_cnt <= r_cnt - c_one;
            end
        end
    end

    // Tick is independent of i_load so the owner may reload on a tick cycle
    assign o_tick = i_en && (r_cnt == '0);

endmodule : seq_interval_timer
`default_nettype wire

// File: rtl/signal_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : signal_seq_ctrl
// Description : Acquisition scheduler running the nested frame -> pixel ->
//               laser loop. Latches loop counts on start, emits registered
//               one-cycle frame_start / pixel_start / laser_fire pulses, and
//               waits for txdone between frames with a timeout.
//               Optional build macro SEQ_CONTINUOUS_EN adds input cont_mode;
//               when latched high, the acquisition restarts at frame 0 after
//               the last frame instead of finishing, until abort.
// Revision    : 1.0  initial release
// ============================================================================
module signal_seq_ctrl
    import signal_seq_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DFLT,
    parameter int unsigned PER_W      = PER_W_DFLT,
    parameter int unsigned TX_TIMEOUT = TX_TIMEOUT_DFLT
) (
    input  logic             sys_clk_100M,
    input  logic             reset,
`ifdef SEQ_CONTINUOUS_EN
    input  logic             cont_mode,
`endif
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] frame_nums,
    input  logic [CNT_W-1:0] pixel_nums,
    input  logic [CNT_W-1:0] laser_nums,
    input  logic [PER_W-1:0] laser_period,
    input  logic             txdone,
    output logic             frame_start,
    output logic             pixel_start,
    output logic             laser_fire,
    output logic [CNT_W-1:0] frame_idx,
    output logic [CNT_W-1:0] pixel_idx,
    output logic             busy,
    output logic             done,
    output logic             err_timeout
);

    localparam int unsigned      TXC_W     = $clog2(TX_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
    localparam logic [PER_W-1:0] c_per_one = PER_W'(1);
    localparam logic [TXC_W-1:0] c_tx_last = TXC_W'(TX_TIMEOUT - 1);
    localparam logic [TXC_W-1:0] c_tx_one  = TXC_W'(1);

    seq_state_t       r_state;

    // Latched configuration
    logic [CNT_W-1:0] r_frame_n;
    logic [CNT_W-1:0] r_pixel_n;
    logic [CNT_W-1:0] r_laser_n;
    logic [PER_W-1:0] r_period;

    // Progress counters
    logic [CNT_W-1:0] r_frame_idx;
    logic [CNT_W-1:0] r_pixel_idx;
    logic [CNT_W-1:0] r_shot_idx;   // index of the next shot to issue
    logic [TXC_W-1:0] r_tx_cnt;

    // Registered outputs
    logic             r_frame_start;
    logic             r_pixel_start;
    logic             r_laser_fire;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    // Terminal values, compared as n-1 so a count of 2^CNT_W-1 never wraps
    logic [CNT_W-1:0] w_frame_nm1;
    logic [CNT_W-1:0] w_pixel_nm1;
    logic [CNT_W-1:0] w_laser_nm1;
    logic             w_any_zero;
    logic             w_restart;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_tmr_tick;

    assign w_frame_nm1 = r_frame_n - c_one;
    assign w_pixel_nm1 = r_pixel_n - c_one;
    assign w_laser_nm1 = r_laser_n - c_one;
    assign w_any_zero  = (frame_nums == '0) || (pixel_nums == '0) || (laser_nums == '0);

`ifdef SEQ_CONTINUOUS_EN
    logic r_cont;

    // Continuous-mode select, sampled together with the other config
    always_ff @(posedge sys_clk_100M or posedge reset) begin
        if (reset) begin
            r_cont <= 1'b0;
        end else if (r_state == S_IDLE && start && !abort) begin
            r_cont <= cont_mode;
        end
    end

    assign w_restart = r_cont;
`else
    assign w_restart = 1'b0;
`endif

    // The timer spaces laser shots and times the post-pixel gap. It is
    // (re)loaded on the edge that issues the first shot of a pixel and on
    // the edge that issues the last shot, which is also the edge into GAP.
    assign w_tmr_en   = (r_state == S_LASER) || (r_state == S_GAP);
    assign w_tmr_load = (r_state == S_PIXEL) ||
                        ((r_state == S_LASER) && w_tmr_tick && (r_shot_idx == w_laser_nm1));

    seq_interval_timer #(
        .W (PER_W)
    ) u_timer (
        .clk      (sys_clk_100M),
        .rst      (reset),
        .i_load   (w_tmr_load),
        .i_en     (w_tmr_en),
        .i_period (r_period),
        .o_tick   (w_tmr_tick)
    );

    // Scheduler FSM: state, counters, latched config and all outputs
    always_ff @(posedge sys_clk_100M or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_frame_n     <= '0;
            r_pixel_n     <= '0;
            r_laser_n     <= '0;
            r_period      <= '0;
            r_frame_idx   <= '0;
            r_pixel_idx   <= '0;
            r_shot_idx    <= '0;
            r_tx_cnt      <= '0;
            r_frame_start <= 1'b0;
            r_pixel_start <= 1'b0;
            r_laser_fire  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_pixel_start <= 1'b0;
            r_laser_fire  <= 1'b0;
            r_done        <= 1'b0;

            if (abort) begin
                // Abort beats everything; indices and err_timeout are kept
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_frame_n <= frame_nums;
                            r_pixel_n <= pixel_nums;
                            r_laser_n <= laser_nums;
                            r_period  <= (laser_period == '0) ? c_per_one : laser_period;
                            r_err     <= 1'b0;
                            if (w_any_zero) begin
                                r_done <= 1'b1;
                            end else begin
                                r_state       <= S_FRAME;
                                r_frame_start <= 1'b1;
                                r_busy        <= 1'b1;
                                r_frame_idx   <= '0;
                                r_pixel_idx   <= '0;
                            end
                        end
                    end

                    S_FRAME: begin
                        r_state       <= S_PIXEL;
                        r_pixel_start <= 1'b1;
                    end

                    S_PIXEL: begin
                        // First shot of the pixel; a single-shot pixel goes
                        // straight to the gap
                        r_laser_fire <= 1'b1;
                        r_shot_idx   <= c_one;
                        r_state      <= (w_laser_nm1 == '0) ? S_GAP : S_LASER;
                    end

                    S_LASER: begin
                        if (w_tmr_tick) begin
                            r_laser_fire <= 1'b1;
                            if (r_shot_idx == w_laser_nm1) begin
                                r_state <= S_GAP;
                            end else begin
                                r_shot_idx <= r_shot_idx + c_one;
                            end
                        end
                    end

                    S_GAP: begin
                        if (w_tmr_tick) begin
                            if (r_pixel_idx == w_pixel_nm1) begin
                                r_state  <= S_WAIT_TX;
                                r_tx_cnt <= '0;
                            end else begin
                                r_state       <= S_PIXEL;
                                r_pixel_idx   <= r_pixel_idx + c_one;
                                r_pixel_start <= 1'b1;
                            end
                        end
                    end

                    S_WAIT_TX: begin
                        if (txdone) begin
                            if ((r_frame_idx != w_frame_nm1) || w_restart) begin
                                r_state       <= S_FRAME;
                                r_frame_start <= 1'b1;
                                r_frame_idx   <= (r_frame_idx == w_frame_nm1) ? '0
                                                                               : r_frame_idx + c_one;
                                r_pixel_idx   <= '0;
                            end else begin
                                r_state <= S_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end
                        end else if (r_tx_cnt == c_tx_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + c_tx_one;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign frame_start = r_frame_start;
    assign pixel_start = r_pixel_start;
    assign laser_fire  = r_laser_fire;
    assign frame_idx   = r_frame_idx;
    assign pixel_idx   = r_pixel_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err_timeout = r_err;

endmodule : signal_seq_ctrl
`default_nettype wire
